// File: rtl/vga_sync_monitor.sv
// Watches a VGA hsync/vsync/de stream, rebuilds pixel coordinates and checks
// line and frame timing against the expected mode, locking after clean frames.
module vga_sync_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        hsync_ni,
  input  logic        vsync_ni,
  input  logic        de_i,
  input  logic        clr_err_i,
  output logic        locked_o,
  output logic        lock_lost_o,
  output logic        frame_done_o,
  output logic        rx_valid_o,
  output logic [9:0]  rx_hpos_o,
  output logic [9:0]  rx_vpos_o,
  output logic [11:0] line_len_o,
  output logic [10:0] frame_lines_o,
  output logic [4:0]  err_flags_o,
  output logic [7:0]  err_count_o
);

  // state      | meaning
  // ST_SEARCH  | waiting for the first vsync fall, no checks run
  // ST_MEASURE | checking timing, counting consecutive clean frames
  // ST_LOCKED  | LOCK_FRAMES clean frames seen, any error drops lock
  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  state_t      state;
  logic        hs1, hs2, vs1, vs2, de1, de2;
  logic        hs_fall, hs_rise, vs_fall, de_rise, de_fall;
  logic [11:0] hcnt, hlow, derun;
  logic [10:0] vcnt, vact;
  logic        h_ref, de_seen, frame_err;
  logic [3:0]  good, good_next;
  logic [12:0] line_period;
  logic [4:0]  new_err;
  logic        any_err, checking, line_has_de;

  assign hs_fall     = hs2 & ~hs1;
  assign hs_rise     = ~hs2 & hs1;
  assign vs_fall     = vs2 & ~vs1;
  assign de_rise     = ~de2 & de1;
  assign de_fall     = de2 & ~de1;
  assign line_period = {1'b0, hcnt} + 13'd1;
  assign checking    = (state != ST_SEARCH);
  assign good_next   = good + 4'd1;
  // a de rise starts a new active line if it is the first since the last hsync fall
  assign line_has_de = de_rise & (hs_fall | ~de_seen);

  always_comb begin
    new_err = '0;
    if (checking) begin
      new_err[0] = hs_fall & h_ref & (line_period != 13'(H_TOTAL));
      new_err[1] = hs_rise & (hlow != 12'(H_SYNC));
      new_err[2] = de_fall & (derun != 12'(H_ACTIVE));
      new_err[3] = vs_fall & (vcnt != 11'(V_TOTAL));
      new_err[4] = vs_fall & (vact != 11'(V_ACTIVE));
    end
  end

  assign any_err = |new_err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= ST_SEARCH;
      {hs1, vs1, de1} <= '0;
      {hs2, vs2, de2} <= '0;
      hcnt          <= '0;
      hlow          <= '0;
      derun         <= '0;
      vcnt          <= '0;
      vact          <= '0;
      h_ref         <= 1'b0;
      de_seen       <= 1'b0;
      frame_err     <= 1'b0;
      good          <= '0;
      locked_o      <= 1'b0;
      lock_lost_o   <= 1'b0;
      frame_done_o  <= 1'b0;
      rx_valid_o    <= 1'b0;
      rx_hpos_o     <= '0;
      rx_vpos_o     <= '0;
      line_len_o    <= '0;
      frame_lines_o <= '0;
      err_flags_o   <= '0;
      err_count_o   <= '0;
    end else begin
      {hs1, vs1, de1} <= {hsync_ni, vsync_ni, de_i};
      {hs2, vs2, de2} <= {hs1, vs1, de1};

      if (hs_fall) begin
        hcnt  <= '0;
        hlow  <= 12'd1;
        h_ref <= 1'b1;
        if (h_ref) line_len_o <= line_period[12] ? 12'hFFF : line_period[11:0];
      end else begin
        if (hcnt != 12'hFFF) hcnt <= hcnt + 12'd1;
        if (!hs1 && hlow != 12'hFFF) hlow <= hlow + 12'd1;
      end

      if (de_rise) derun <= 12'd1;
      else if (de1 && derun != 12'hFFF) derun <= derun + 12'd1;

      if (hs_fall) de_seen <= de_rise;
      else if (de_rise) de_seen <= 1'b1;

      if (vs_fall) begin
        vcnt <= {10'd0, hs_fall};
        vact <= {10'd0, line_has_de};
        if (checking) frame_lines_o <= vcnt;
      end else begin
        if (hs_fall && vcnt != 11'h7FF) vcnt <= vcnt + 11'd1;
        if (line_has_de && vact != 11'h7FF) vact <= vact + 11'd1;
      end

      rx_valid_o <= de1;
      if (!de1) rx_hpos_o <= '0;
      else if (!rx_valid_o) rx_hpos_o <= '0;
      else if (rx_hpos_o != 10'h3FF) rx_hpos_o <= rx_hpos_o + 10'd1;

      if (vs_fall) rx_vpos_o <= '0;
      else if (de_fall && rx_vpos_o != 10'h3FF) rx_vpos_o <= rx_vpos_o + 10'd1;

      // a flag raised in the same cycle as a clear survives the clear
      if (clr_err_i) err_flags_o <= new_err;
      else err_flags_o <= err_flags_o | new_err;
      if (any_err && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;

      if (vs_fall) frame_err <= 1'b0;
      else if (any_err) frame_err <= 1'b1;

      lock_lost_o  <= 1'b0;
      frame_done_o <= checking & vs_fall;

      case (state)
        ST_SEARCH: begin
          locked_o <= 1'b0;
          if (vs_fall) begin
            state <= ST_MEASURE;
            good  <= '0;
          end
        end
        ST_MEASURE: begin
          if (any_err) begin
            good <= '0;
          end else if (vs_fall && !frame_err) begin
            good <= good_next;
            if (good_next == 4'(LOCK_FRAMES)) begin
              state    <= ST_LOCKED;
              locked_o <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (any_err) begin
            state       <= ST_MEASURE;
            good        <= '0;
            locked_o    <= 1'b0;
            lock_lost_o <= 1'b1;
          end
        end
        default: begin
          state    <= ST_SEARCH;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down video mode
// (24 clocks x 10 lines) so several frames fit in a short run.
module tb_vga_sync_monitor;

  localparam int HA     = 16;
  localparam int HT     = 24;
  localparam int HS     = 4;
  localparam int HSTART = 18;
  localparam int VA     = 6;
  localparam int VT     = 10;
  localparam int VSTART = 7;
  localparam int VSW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_n = 1'b1;
  logic        vsync_n = 1'b1;
  logic        de = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked, lock_lost, frame_done, rx_valid;
  logic [9:0]  rx_hpos, rx_vpos;
  logic [11:0] line_len;
  logic [10:0] frame_lines;
  logic [4:0]  err_flags;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int tick = 0;
  int vs_fall_tick = 0;

  logic mon_clr = 1'b0;
  int   seq_err = 0, valid_cnt = 0, fd_cnt = 0, ll_cnt = 0, lock_rise_tick = 0;
  int   max_hpos = 0, max_vpos = 0, min_peak = 1023, prev_hpos = 0;
  logic prev_valid = 1'b0, locked_prev = 1'b0;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC(HS),
    .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .clk_i(clk), .reset_i(rst), .hsync_ni(hsync_n), .vsync_ni(vsync_n),
    .de_i(de), .clr_err_i(clr_err),
    .locked_o(locked), .lock_lost_o(lock_lost), .frame_done_o(frame_done),
    .rx_valid_o(rx_valid), .rx_hpos_o(rx_hpos), .rx_vpos_o(rx_vpos),
    .line_len_o(line_len), .frame_lines_o(frame_lines),
    .err_flags_o(err_flags), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  // coordinate and pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (mon_clr) begin
      seq_err   <= 0;
      valid_cnt <= 0;
      fd_cnt    <= 0;
      ll_cnt    <= 0;
      max_hpos  <= 0;
      max_vpos  <= 0;
      min_peak  <= 1023;
    end else begin
      if (rx_valid) begin
        if (int'(rx_hpos) != (prev_valid ? prev_hpos + 1 : 0)) seq_err <= seq_err + 1;
        valid_cnt <= valid_cnt + 1;
        if (int'(rx_hpos) > max_hpos) max_hpos <= int'(rx_hpos);
        if (int'(rx_vpos) > max_vpos) max_vpos <= int'(rx_vpos);
      end else begin
        if (rx_hpos != 10'd0) seq_err <= seq_err + 1;
        if (prev_valid && prev_hpos < min_peak) min_peak <= prev_hpos;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (lock_lost) ll_cnt <= ll_cnt + 1;
      if (locked && !locked_prev) lock_rise_tick <= tick;
    end
    prev_valid  <= rx_valid;
    prev_hpos   <= int'(rx_hpos);
    locked_prev <= locked;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one pixel clock: outputs seen here reflect the pins driven two calls earlier
  task automatic pix(input logic hs, input logic vs, input logic d);
    @(posedge clk);
    #1;
    tick++;
    if (rst) begin
      chk_eq("rst_ctl", {locked, lock_lost, frame_done, rx_valid, err_flags, err_count}, 32'd0);
      chk_eq("rst_pos", {rx_hpos, rx_vpos}, 32'd0);
      chk_eq("rst_len", {line_len, frame_lines}, 32'd0);
      rst = 1'b0;
    end
    if (vsync_n && !vs) vs_fall_tick = tick;
    hsync_n = hs;
    vsync_n = vs;
    de      = d;
  endtask

  task automatic run_frame(input int long_line, input int short_hs_line, input int short_de_line,
                           input int clr_line, input bit drop_first, input int rst_line);
    for (int l = (drop_first ? 1 : 0); l < VT; l++) begin
      int plen;
      plen = (l == long_line) ? HT + 1 : HT;
      for (int p = 0; p < plen; p++) begin
        int   hs_end, de_end;
        logic hs_v, vs_v, de_v;
        hs_end = (l == short_hs_line) ? HSTART + HS - 1 : HSTART + HS;
        de_end = (l == short_de_line) ? HA - 1 : HA;
        hs_v = !(p >= HSTART && p < hs_end);
        vs_v = !(l >= VSTART && l < VSTART + VSW);
        de_v = (l < VA) && (p < de_end);
        pix(hs_v, vs_v, de_v);
        if (l == clr_line) clr_err = (p == hs_end + 1);
        if (l == rst_line && p == 5) rst = 1'b1;
      end
    end
  endtask

  task automatic frame_nominal();
    run_frame(-1, -1, -1, -1, 1'b0, -1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(4);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic lock_up();
    do_reset();
    for (int f = 0; f < 3; f++) frame_nominal();
  endtask

  initial begin
    // nominal stream, lock on the third vsync fall
    do_reset();
    frame_nominal();
    frame_nominal();
    chk_eq("lock_f2", locked, 0);
    frame_nominal();
    chk_eq("lock_f3", locked, 1);
    chk_eq("lock_lat", lock_rise_tick - vs_fall_tick, 2);
    clear_mon();
    frame_nominal();
    chk_eq("line_len", line_len, HT);
    chk_eq("frame_lines", frame_lines, VT);
    chk_eq("flags_nom", err_flags, 0);
    chk_eq("count_nom", err_count, 0);
    chk_eq("hpos_seq", seq_err, 0);
    chk_eq("hpos_max", max_hpos, HA - 1);
    chk_eq("hpos_minpk", min_peak, HA - 1);
    chk_eq("vpos_max", max_vpos, VA - 1);
    chk_eq("valid_cnt", valid_cnt, HA * VA);
    chk_eq("fdone_cnt", fd_cnt, 1);
    chk_eq("lock_f4", locked, 1);

    // one long line while locked
    clear_mon();
    run_frame(2, -1, -1, -1, 1'b0, -1);
    chk_eq("long_flags", err_flags, 5'b00001);
    chk_eq("long_count", err_count, 1);
    chk_eq("lost_pulse", ll_cnt, 1);
    chk_eq("long_lock", locked, 0);
    frame_nominal();
    chk_eq("relock_f6", locked, 0);
    frame_nominal();
    chk_eq("relock_f7", locked, 1);

    // reset mid-frame then relock
    run_frame(-1, -1, -1, -1, 1'b0, 3);
    chk_eq("post_rst_f8", locked, 0);
    frame_nominal();
    chk_eq("post_rst_f9", locked, 0);
    frame_nominal();
    chk_eq("post_rst_lock", locked, 1);
    chk_eq("post_rst_flags", err_flags, 0);
    chk_eq("post_rst_count", err_count, 0);
    chk_eq("post_rst_len", line_len, HT);

    // short hsync and short de run on separate lines
    lock_up();
    clear_mon();
    run_frame(-1, 2, 3, -1, 1'b0, -1);
    chk_eq("short_flags", err_flags, 5'b00110);
    chk_eq("short_count", err_count, 2);
    chk_eq("short_peak", min_peak, HA - 2);
    chk_eq("short_lock", locked, 0);

    // frame one line short, one active line short
    lock_up();
    run_frame(-1, -1, -1, -1, 1'b1, -1);
    chk_eq("frame_flags", err_flags, 5'b11000);
    chk_eq("frame_count", err_count, 1);
    chk_eq("frame_lines_s", frame_lines, VT - 1);

    // clear racing a new error, then a long hsync-high gap
    lock_up();
    run_frame(-1, -1, 1, -1, 1'b0, -1);
    chk_eq("clr_pre", err_flags, 5'b00100);
    run_frame(-1, 2, -1, 2, 1'b0, -1);
    chk_eq("clr_race", err_flags, 5'b00010);
    chk_eq("clr_count", err_count, 2);
    idle(1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(2);
    chk_eq("clr_flags", err_flags, 0);
    idle(5000);
    frame_nominal();
    chk_eq("sat_flags", err_flags, 5'b00001);
    chk_eq("sat_count", err_count, 3);
    chk_eq("sat_len", line_len, HT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: watches hsync/vsync/display-enable on the VGA pixel clock and reconstructs pixel coordinates from the sync stream.
- Measures line and frame timing, checks it against parameterised 640x480 timing, and runs a lock state machine.
- Sits beside the VGA output path as a self-check / on-board monitor.

Parameters:
- H_ACTIVE, 640, active pixels per line (de high run length).
- H_TOTAL, 800, clocks per line (hsync fall to hsync fall).
- H_SYNC, 96, hsync low width in clocks.
- V_ACTIVE, 480, lines per frame containing de.
- V_TOTAL, 525, lines per frame (hsync falls between vsync falls).
- LOCK_FRAMES, 2, consecutive clean frames required to lock (1..15).

Ports:
- clk_i  in  1  VGA pixel clock.
- reset_i  in  1  synchronous, active-high reset.
- hsync_ni  in  1  horizontal sync, active low.
- vsync_ni  in  1  vertical sync, active low.
- de_i  in  1  display enable, active high.
- clr_err_i  in  1  clears err_flags_o.
- locked_o  out  1  timing locked.
- lock_lost_o  out  1  one-cycle pulse on LOCKED->MEASURE.
- frame_done_o  out  1  one-cycle pulse per vsync fall in MEASURE/LOCKED.
- rx_valid_o  out  1  de aligned with rx_hpos_o/rx_vpos_o.
- rx_hpos_o  out  10  active pixel index within line.
- rx_vpos_o  out  10  active line index within frame.
- line_len_o  out  12  last measured line period.
- frame_lines_o  out  11  last measured lines per frame.
- err_flags_o  out  5  sticky errors: [0] line period, [1] hsync width, [2] de run length, [3] total lines, [4] active lines.
- err_count_o  out  8  saturating error-event count.

Behaviour:
- Input stage: pins registered once (s1), then again (s2). Edges are s1 vs s2.
- All registered outputs update on the clock after edge detection, i.e. 2 clk_i cycles after the pin is first sampled changed.
- Reset: all outputs 0, FSM=SEARCH, counters 0, h_ref=0.
- Counters:
  - hcnt (12b) clears on hsync fall, otherwise increments, saturating at 4095.
  - hlow counts hsync-low clocks.
  - derun counts de-high clocks.
  - vcnt (11b, saturating) counts hsync falls since the last vsync fall.
  - vact counts lines containing at least one de-high clock.
  - h_ref sets at the first hsync fall after reset.
- Checks run only in MEASURE/LOCKED:
  - [0] at hsync fall: (hcnt+1)!=H_TOTAL, and h_ref was already set. line_len_o<=hcnt+1 on every hsync fall once h_ref=1.
  - [1] at hsync rise: hlow!=H_SYNC.
  - [2] at de fall: derun!=H_ACTIVE.
  - [3] at vsync fall: vcnt!=V_TOTAL. frame_lines_o<=vcnt.
  - [4] at vsync fall: vact!=V_ACTIVE.
- Error handling:
  - Any failing check sets its flag bit and increments err_count_o (saturates at 255).
  - Multiple failures in one cycle count as one event.
  - clr_err_i clears the flags; a flag set in the same cycle wins.
- FSM:
  - SEARCH -> MEASURE on vsync fall; good=0; vcnt/vact clear; no frame check on this edge.
  - MEASURE, on any error: good=0, stay in MEASURE.
  - MEASURE, on vsync fall with no error during the frame: good+1; if good+1==LOCK_FRAMES go to LOCKED.
  - LOCKED, on any error: go to MEASURE, good=0, pulse lock_lost_o.
  - locked_o=1 iff state==LOCKED.
  - frame_done_o pulses on every vsync fall in MEASURE/LOCKED, including the transition edge.
- Coordinates:
  - rx_valid_o = s1 de delayed 1.
  - rx_hpos_o counts 0.. across the de run and clears when de is low.
  - rx_vpos_o increments at each de fall and clears at vsync fall.
  - Both saturate at 1023.
  - Valid in every state.
- Missing syncs: counters saturate, no wrap. The error is detected at the next edge.
- Reset mid-frame: immediate return to reset values. The first line after reset is never period-checked (h_ref=0).

Test Plan:
1. Nominal 640x480 generator (800x525, hsync 96), 4 frames
   - locked_o rises 2 cycles after the 3rd vsync fall.
   - line_len_o=800, frame_lines_o=525, err_flags_o=0, err_count_o=0.
   - rx_hpos_o runs 0..639 and rx_vpos_o runs 0..479 with rx_valid_o.
2. Locked, one 801-clock line in frame 5
   - err_flags_o[0]=1, err_count_o=1, lock_lost_o one-cycle pulse, locked_o=0.
   - Relocks after 2 further clean frames.
3. hsync low 95 clocks on one line
   - err_flags_o[1]=1.
   - de run of 639 on another line -> err_flags_o[2]=1, rx_hpos_o peaks at 638.
   - err_count_o=2.
4. Frame of 524 lines with 479 active
   - err_flags_o[3]=1 and [4]=1, err_count_o increments by exactly 1, frame_lines_o=524.
5. reset_i for 1 cycle mid-frame
   - Next cycle all outputs 0 and FSM in SEARCH.
   - No [0] error on the first post-reset line; relocks per scenario 1.
6. clr_err_i asserted in the same cycle as a new [1] error -> err_flags_o=5'b00010.
   - hsync held high 5000 clocks -> hcnt saturates; err_flags_o[0] sets at the next hsync fall.
